// File: rtl/instr_encoder_if.sv
// Request/response bundle of the RV32I instruction encoder: decoded fields in,
// encoded word plus instruction-memory write address out.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] addr;

    modport master (
        output in_valid, op, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, instr, addr
    );

    modport slave (
        input  in_valid, op, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, instr, addr
    );
endinterface

// File: rtl/instr_encoder.sv
// Assembles RV32I words from decoded fields into a 2-entry FIFO drained with a write address.
// Define INSTR_ENCODER_UTYPE_EN to accept LUI/AUIPC; otherwise they count as illegal.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    instr_encoder_if.slave   bus,
    output logic             err,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
`ifdef INSTR_ENCODER_UTYPE_EN
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [31:0] addr_q;

    logic        legal;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        pop;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (bus.op)
            OP_R:
                word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.op};
            OP_I_ALU, OP_LOAD:
                word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.op};
            OP_S:
                word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.op};
            OP_B:
                word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[4:1], bus.imm[11], bus.op};
            OP_J:
                word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.op};
`ifdef INSTR_ENCODER_UTYPE_EN
            OP_LUI, OP_AUIPC:
                word = {bus.imm[31:12], bus.rd, bus.op};
`endif
            default:
                legal = 1'b0;
        endcase
    end

    // in_ready depends only on registered count, never on out_ready.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.instr     = bus.out_valid ? mem[rd_ptr] : 32'h0;
    assign bus.addr      = addr_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && legal && !clr;
    assign pop    = bus.out_valid && bus.out_ready;

    // NOTE: the storage array has no reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            addr_q      <= BASE_ADDR;
            err         <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                addr_q <= addr_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (accept && !legal) begin
                err <= 1'b1;
                if (illegal_cnt != '1) begin
                    illegal_cnt <= illegal_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected words/addresses,
// a negedge monitor pops and compares on every output handshake.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          CW   = 8;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          err;
    logic [CW-1:0] illegal_cnt;

    instr_encoder_if bus ();

    instr_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .bus         (bus),
        .err         (err),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_addr = BASE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: every completed output handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && !clr && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got instr %h addr %h, expected none",
                         bus.instr, bus.addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("instr", bus.instr, e.instr);
                check("addr", bus.addr, e.addr);
            end
        end
    end

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input bit legal, input logic [31:0] word);
        int cyc = 0;
        bus.op = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_total++;
            $display("FAIL send_timeout: in_ready stuck at 0 for op %b, expected 1", op);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (legal) begin
                exp_t e;
                e.instr = word;
                e.addr  = exp_addr;
                exp_q.push_back(e);
                exp_addr += 32'd4;
            end
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic do_clr(input bit with_req);
        if (with_req) begin
            bus.op = 7'b0010011; bus.rd = 5'd7; bus.rs1 = 5'd0; bus.funct3 = 3'd0; bus.imm = 32'd9;
            bus.in_valid = 1'b1;
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        exp_addr = BASE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
        idle(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_addr", bus.addr, BASE);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        idle(1);

        // I-type, latency 1
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
        @(negedge clk);
        check("latency1_valid", {31'd0, bus.out_valid}, 32'd1);
        idle(2);

        // Back-to-back R then S from address 0
        do_clr(1'b0);
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b1, 32'h0020_81B3);
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b1, 32'h0020_A423);
        idle(3);

        // Branch and jump
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8, 1'b1, 32'h0080_00EF);
        idle(3);

        // Backpressure: two accepted, third stalls, head stable
        do_clr(1'b0);
        bus.out_ready = 1'b0;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
        send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 1'b1, 32'h0010_0113);
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        fork
            send(7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, 1'b1, 32'h0020_0193);
        join_none
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid_held", {31'd0, bus.out_valid}, 32'd1);
            check("bp_instr_stable", bus.instr, 32'h0050_0093);
            check("bp_addr_stable", bus.addr, BASE);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait fork;
        idle(4);

        // Illegal opcode and saturation
        send(7'b1111111, 5'd1, 5'd1, 5'd1, 3'b000, 7'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        check("illegal_err", {31'd0, err}, 32'd1);
        check("illegal_cnt1", {24'd0, illegal_cnt}, 32'd1);
        check("illegal_no_output", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 299; i++) begin
            send(7'b1111111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 1'b0, 32'd0);
        end
        @(negedge clk);
        check("illegal_cnt_sat", {24'd0, illegal_cnt}, 32'd255);
        check("illegal_err_sticky", {31'd0, err}, 32'd1);
        idle(1);

        // clr with a simultaneous request: request discarded, state cleared
        do_clr(1'b1);
        @(negedge clk);
        check("clr_err", {31'd0, err}, 32'd0);
        check("clr_cnt", {24'd0, illegal_cnt}, 32'd0);
        check("clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("clr_addr", bus.addr, BASE);
        check("clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        idle(1);

        // clr mid-stream drops the buffered word; next word lands at BASE
        bus.out_ready = 1'b0;
        send(7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 1'b1, 32'h0030_0213);
        @(negedge clk);
        check("mid_buffered", {31'd0, bus.out_valid}, 32'd1);
        idle(1);
        do_clr(1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("mid_flushed", {31'd0, bus.out_valid}, 32'd0);
        idle(1);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8, 1'b1, 32'h0080_00EF);
        idle(3);

        // U-type, legal only when the option is built in
`ifdef INSTR_ENCODER_UTYPE_EN
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
        @(negedge clk);
        check("lui_valid", {31'd0, bus.out_valid}, 32'd1);
        check("lui_err", {31'd0, err}, 32'd0);
`else
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 1'b0, 32'd0);
        @(negedge clk);
        check("lui_illegal_err", {31'd0, err}, 32'd1);
        check("lui_no_output", {31'd0, bus.out_valid}, 32'd0);
        check("lui_cnt", {24'd0, illegal_cnt}, 32'd1);
`endif
        idle(5);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Reverse direction of the main/ALU control decode path: accepts decoded instruction fields (opcode, registers, funct3/funct7, immediate) and assembles legal RV32I 32-bit instruction words.
- Words are buffered in a 2-entry FIFO and drained over a valid/ready port that carries an instruction-memory write address.
- Used by the test/boot loader to fill instruction memory and to cross-check the control decode path.

Parameters:
- BASE_ADDR, 32'h0000_0000, instruction-memory address of the first emitted word; also the value restored by reset and clr.
- CNT_W, 8, width of the illegal-request counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous pulse: address back to BASE_ADDR, FIFO flushed, err/illegal_cnt cleared.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- op  input  7  opcode.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field; used only for R-type.
- imm  input  32  sign-extended byte immediate.
- out_valid  output  1  instr/addr valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- instr  output  32  encoded word at FIFO head.
- addr  output  32  write address for instr.
- err  output  1  sticky: set by any illegal request.
- illegal_cnt  output  CNT_W  saturating count of illegal requests.

Behaviour:
- Reset (rst=1) values:
  - FIFO empty; out_valid=0; instr=0.
  - addr=BASE_ADDR; err=0; illegal_cnt=0.
  - in_ready=1 from the first cycle after reset.
- in_ready = (FIFO count != 2). There is no combinational path from out_ready to in_ready.
- Accepted legal request is encoded combinationally and pushed into the FIFO. It appears on instr with out_valid=1 the next cycle if the FIFO was empty (latency 1).
- Encoding by op:
  - 0110011 R: funct7|rs2|rs1|funct3|rd|op.
  - 0010011 I-ALU and 0000011 load: imm[11:0]|rs1|funct3|rd|op.
  - 0100011 S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - 1100011 B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - 1101111 J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Unused fields are ignored. Immediate bits above the field are truncated, with no range check. imm[0] is ignored for B/J.
- Any other op is illegal:
  - The request is consumed (handshake completes) and not pushed.
  - err set.
  - illegal_cnt += 1, saturating at all-ones.
- Pop on out_valid && out_ready. addr advances by 4 per pop and wraps modulo 2^32.
- Simultaneous push and pop:
  - count 1: count stays 1; the new word becomes head on the next cycle.
  - count 0: push only, since out_valid=0.
  - count 2: no push is possible (in_ready=0); pop only.
- out_valid held high with instr/addr stable until popped (no retraction).
- clr:
  - Same effect as rst on FIFO, addr, err and illegal_cnt.
  - A request accepted in the clr cycle is discarded.
  - rst has priority over clr.
- Reset or clr mid-stream: buffered words are lost; the next emitted word goes to BASE_ADDR.
- FIFO is two registered entries with read/write pointers (1 bit each) and a 2-bit count.

Optional Feature:
- Macro: INSTR_ENCODER_UTYPE_EN.
- Defined:
  - op 0110111 (LUI) and 0010111 (AUIPC) are legal and encoded imm[31:12]|rd|op.
  - imm carries the full upper value; imm[11:0] is ignored.
- Undefined: both opcodes are illegal (err, illegal_cnt), exactly like any other unsupported op.

Test Plan:
- Reset, then request op=0010011 rd=1 rs1=0 f3=000 imm=5 -> next cycle out_valid=1, instr=0x00500093, addr=BASE_ADDR.
- Back-to-back R-type rd=3 rs1=1 rs2=2 f3=0 f7=0 and S-type rs1=1 rs2=2 f3=010 imm=8, both popped -> 0x002081B3 at addr 0, then 0x0020A423 at addr 4.
- Branch and jump:
  - op=1100011 rs1=1 rs2=2 f3=0 imm=-4 -> 0xFE208EE3.
  - op=1101111 rd=1 imm=8 -> 0x008000EF.
- Backpressure:
  - out_ready=0 with 3 requests -> in_ready drops after 2 accepts; out_valid and instr stay stable.
  - Release -> words emitted in order, addresses 0, 4, 8.
- Illegal and clear:
  - op=1111111 -> accepted, no output, err=1, illegal_cnt=1.
  - 300 illegal requests -> illegal_cnt saturates at 255.
  - clr pulse -> err=0, illegal_cnt=0, FIFO empty, addr=BASE_ADDR.
- Optional feature:
  - With INSTR_ENCODER_UTYPE_EN: op=0110111 rd=5 imm=0x12345000 -> 0x123452B7.
  - Without it: the same request sets err=1 and emits nothing.
